// File: rtl/traffic_light_monitor.sv
// Passive checker for a red/green/yellow lamp interface: tracks the phase, measures phase
// lengths and flags order, one-hot and duration violations with sticky error bits.
module traffic_light_monitor #(
  parameter int unsigned red_time    = 30,
  parameter int unsigned yellow_time = 5,
  parameter int unsigned green_time  = 25,
  parameter int unsigned TOL         = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red_light,
  input  logic             yellow_light,
  input  logic             green_light,
  input  logic             err_clr,
  output logic [1:0]       phase,
  output logic             phase_done,
  output logic [CNT_W-1:0] phase_len,
  output logic [15:0]      cycle_count,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             timing_err
);

  typedef enum logic [1:0] {
    StAcquire = 2'd0,
    StRed     = 2'd1,
    StGreen   = 2'd2,
    StYellow  = 2'd3
  } phase_e;

  // Widened by one bit so expected+TOL+1 never wraps.
  localparam logic [CNT_W:0]   RedLen    = red_time[CNT_W:0];
  localparam logic [CNT_W:0]   YellowLen = yellow_time[CNT_W:0];
  localparam logic [CNT_W:0]   GreenLen  = green_time[CNT_W:0];
  localparam logic [CNT_W:0]   TolW      = TOL[CNT_W:0];
  localparam logic [CNT_W-1:0] CountOne  = 1;

  phase_e           phase_q;
  phase_e           sample_ph;
  phase_e           succ_ph;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc;
  logic             partial_q;
  logic             valid;
  logic             transition;
  logic             counting;
  logic [CNT_W:0]   exp_len;
  logic [CNT_W:0]   limit;
  logic [CNT_W:0]   count_ext;
  logic [CNT_W:0]   diff;
  logic             overrun;
  logic             off_time;
  logic             set_oh;
  logic             set_seq;
  logic             set_tim;

  always_comb begin
    // XOR is high for one or three lamps; exclude the all-on case.
    valid     = (red_light ^ yellow_light ^ green_light) &
                ~(red_light & yellow_light & green_light);
    sample_ph = red_light ? StRed : (green_light ? StGreen : StYellow);

    exp_len = '0;
    succ_ph = StAcquire;
    unique case (phase_q)
      StRed:    begin exp_len = RedLen;    succ_ph = StGreen;  end
      StGreen:  begin exp_len = GreenLen;  succ_ph = StYellow; end
      StYellow: begin exp_len = YellowLen; succ_ph = StRed;    end
      default:  begin exp_len = '0;        succ_ph = StAcquire; end
    endcase

    count_inc = (count_q == '1) ? count_q : count_q + 1'b1;
    limit     = exp_len + TolW + 1'b1;
    count_ext = {1'b0, count_q};
    diff      = (count_ext > exp_len) ? (count_ext - exp_len) : (exp_len - count_ext);
    off_time  = diff > TolW;
    overrun   = (phase_q != StAcquire) && !partial_q && ({1'b0, count_inc} >= limit);

    transition = valid && (phase_q != StAcquire) && (sample_ph != phase_q);
    counting   = (phase_q != StAcquire) && (!valid || (sample_ph == phase_q));

    set_oh  = ~valid;
    set_seq = transition && (sample_ph != succ_ph);
    set_tim = transition ? (!partial_q && off_time) : (counting && overrun);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q     <= StAcquire;
      count_q     <= '0;
      partial_q   <= 1'b1;
      phase_done  <= 1'b0;
      phase_len   <= '0;
      cycle_count <= '0;
      onehot_err  <= 1'b0;
      seq_err     <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      phase_done <= 1'b0;
      onehot_err <= set_oh  | (onehot_err & ~err_clr);
      seq_err    <= set_seq | (seq_err & ~err_clr);
      timing_err <= set_tim | (timing_err & ~err_clr);

      if (!valid) begin
        count_q <= count_inc;
      end else if (phase_q == StAcquire) begin
        phase_q   <= sample_ph;
        count_q   <= CountOne;
        partial_q <= 1'b1;
      end else if (sample_ph == phase_q) begin
        count_q <= count_inc;
      end else begin
        phase_len  <= count_q;
        phase_done <= 1'b1;
        if (phase_q == StYellow && sample_ph == StRed) begin
          cycle_count <= cycle_count + 16'd1;
        end
        phase_q   <= sample_ph;
        count_q   <= CountOne;
        partial_q <= 1'b0;
      end
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomized bench: three monitors (TOL 0/1/2) share one lamp stream and are checked every
// cycle against a timestamp-based reference model.
module tb_traffic_light_monitor;

  localparam int RT = 30;
  localparam int YT = 5;
  localparam int GT = 25;

  logic            clk = 1'b0;
  logic            reset;
  logic            red;
  logic            yel;
  logic            grn;
  logic            err_clr;
  logic [2:0][1:0] phase;
  logic [2:0]      done;
  logic [2:0][7:0] plen;
  logic [2:0][15:0] cyc;
  logic [2:0]      oh;
  logic [2:0]      sq;
  logic [2:0]      tm;

  int n_checks = 0;
  int n_bad    = 0;

  // Model state: phase number, timestamp of the phase's first sample, and reported outputs.
  int t;
  int m_ph[3];
  int m_start[3];
  int m_part[3];
  int m_len[3];
  int m_cyc[3];
  int m_done[3];
  int m_oh[3];
  int m_sq[3];
  int m_tm[3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    traffic_light_monitor #(
      .red_time   (RT),
      .yellow_time(YT),
      .green_time (GT),
      .TOL        (k),
      .CNT_W      (8)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .red_light   (red),
      .yellow_light(yel),
      .green_light (grn),
      .err_clr     (err_clr),
      .phase       (phase[k]),
      .phase_done  (done[k]),
      .phase_len   (plen[k]),
      .cycle_count (cyc[k]),
      .onehot_err  (oh[k]),
      .seq_err     (sq[k]),
      .timing_err  (tm[k])
    );
  end

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic int exp_of(input int p);
    case (p)
      1: return RT;
      2: return GT;
      3: return YT;
      default: return 0;
    endcase
  endfunction

  function automatic int succ(input int p);
    return (p == 3) ? 1 : p + 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ph[k] = 0; m_start[k] = 0; m_part[k] = 1; m_len[k] = 0; m_cyc[k] = 0;
      m_done[k] = 0; m_oh[k] = 0; m_sq[k] = 0; m_tm[k] = 0;
    end
  endtask

  task automatic model_step(input logic r, input logic y, input logic g, input logic clr);
    for (int k = 0; k < 3; k++) begin
      int  sp, len, e;
      bit  valid, so, ss, st;
      valid = (int'(r) + int'(y) + int'(g)) == 1;
      sp    = r ? 1 : (g ? 2 : 3);
      e     = exp_of(m_ph[k]);
      so = 0; ss = 0; st = 0;
      m_done[k] = 0;
      if (!valid) begin
        so = 1;
        if (m_ph[k] != 0 && m_part[k] == 0 && (t - m_start[k] + 1) >= e + k + 1) st = 1;
      end else if (m_ph[k] == 0) begin
        m_ph[k] = sp; m_start[k] = t; m_part[k] = 1;
      end else if (sp == m_ph[k]) begin
        if (m_part[k] == 0 && (t - m_start[k] + 1) >= e + k + 1) st = 1;
      end else begin
        len = t - m_start[k];
        m_len[k]  = len;
        m_done[k] = 1;
        if (m_part[k] == 0 && (len > e + k || len < e - k)) st = 1;
        if (sp != succ(m_ph[k])) ss = 1;
        if (m_ph[k] == 3 && sp == 1) m_cyc[k]++;
        m_ph[k] = sp; m_start[k] = t; m_part[k] = 0;
      end
      m_oh[k] = (so || (m_oh[k] != 0 && !clr)) ? 1 : 0;
      m_sq[k] = (ss || (m_sq[k] != 0 && !clr)) ? 1 : 0;
      m_tm[k] = (st || (m_tm[k] != 0 && !clr)) ? 1 : 0;
    end
    t++;
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("t%0d k%0d phase", t, k), int'(phase[k]), m_ph[k]);
      check_eq($sformatf("t%0d k%0d done", t, k), int'(done[k]), m_done[k]);
      check_eq($sformatf("t%0d k%0d len", t, k), int'(plen[k]), m_len[k]);
      check_eq($sformatf("t%0d k%0d cyc", t, k), int'(cyc[k]), m_cyc[k]);
      check_eq($sformatf("t%0d k%0d oh", t, k), int'(oh[k]), m_oh[k]);
      check_eq($sformatf("t%0d k%0d seq", t, k), int'(sq[k]), m_sq[k]);
      check_eq($sformatf("t%0d k%0d tim", t, k), int'(tm[k]), m_tm[k]);
    end
  endtask

  task automatic step(input logic r, input logic y, input logic g, input logic clr);
    red = r; yel = y; grn = g; err_clr = clr;
    @(posedge clk);
    #1;
    model_step(r, y, g, clr);
    compare_all();
    err_clr = 1'b0;
  endtask

  task automatic hold(input int p, input int n);
    repeat (n) step(p == 1, p == 3, p == 2, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    model_reset();
    compare_all();
    reset = 1'b1;
  endtask

  int bad_pat[5] = '{0, 3, 5, 6, 7};

  initial begin
    int p, n, e, v;
    logic [2:0] pat;
    reset = 1'b0; red = 1'b0; yel = 1'b0; grn = 1'b0; err_clr = 1'b0;
    t = 0;
    model_reset();
    #19;
    compare_all();
    check_eq("reset_phase", int'(phase[0]), 0);
    check_eq("reset_errs", int'({oh[0], sq[0], tm[0]}), 0);
    #1 reset = 1'b1;

    // Three clean cycles, then close the last yellow.
    for (int i = 0; i < 3; i++) begin
      hold(1, RT); hold(2, GT); hold(3, YT);
    end
    hold(1, RT);
    check_eq("clean_cyc", int'(cyc[0]), 3);
    check_eq("clean_len", int'(plen[0]), YT);
    check_eq("clean_errs", int'({oh, sq, tm}), 0);

    // Green held 27: overrun for TOL=1 on the 27th sample, none for TOL=2.
    hold(2, 26);
    check_eq("g26_tol1", int'(tm[1]), 0);
    hold(2, 1);
    check_eq("g27_tol1", int'(tm[1]), 1);
    hold(3, 1);
    check_eq("g27_tol2", int'(tm[2]), 0);
    hold(3, 3);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    hold(1, RT);

    // Red -> yellow is out of order.
    hold(3, 1);
    check_eq("seq_set", int'(sq[0]), 1);
    hold(3, 4);
    hold(1, 10);
    check_eq("seq_cyc", int'(cyc[0]), 5);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("seq_clr", int'(sq[0]), 0);

    // Red+green glitch mid-red.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("oh_set", int'(oh[0]), 1);
    check_eq("oh_phase", int'(phase[0]), 1);
    hold(1, 18);
    hold(2, 1);
    check_eq("oh_len", int'(plen[0]), RT);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("oh_clr", int'(oh[0]), 0);
    hold(2, GT - 2);
    hold(3, YT);
    hold(1, RT);

    // err_clr coincides with the TOL=0 red overrun: set wins.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("clr_vs_ovr", int'(tm[0]), 1);

    // Reset in the middle of green; the next phase is partial.
    hold(2, 10);
    pulse_reset();
    check_eq("rst_phase", int'(phase[0]), 0);
    check_eq("rst_cyc", int'(cyc[0]), 0);
    hold(2, 5); hold(3, YT); hold(1, RT); hold(2, GT);
    check_eq("partial_ok", int'({oh, sq, tm}), 0);

    // Randomized segments with occasional illegal order, bad samples, clears and a reset.
    p = 2;
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 9) == 0) p = succ(succ(p));
      else p = succ(p);
      e = exp_of(p);
      n = e + int'($urandom_range(0, 4)) - 2;
      if (n < 1) n = 1;
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(0, 29) == 0) begin
          v = bad_pat[$urandom_range(0, 4)];
          pat = v[2:0];
        end else begin
          pat = {p == 1, p == 3, p == 2};
        end
        step(pat[2], pat[1], pat[0], $urandom_range(0, 15) == 0);
        if (s == 40 && c == n / 2) pulse_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
